gray_sequence_decoder: RTL and testbench

Receiver-side companion to the Gray-code counter. It samples a WIDTH-bit Gray-coded bus each valid cycle and converts it to binary. It checks that each new sample is a legal single-step move: +1, -1 or hold, modulo 2^WIDTH. It reports step direction, counts illegal transitions and tracks lock status, so that a Gray-counter source, local or crossing a clock domain, can be consumed and checked downstream.

---
 rtl/gray_pkg.sv | 34 +++
 rtl/gray_to_bin.sv | 16 +
 rtl/gray_sequence_decoder.sv | 166 ++++++++++++++++
 tb/tb_gray_sequence_decoder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types, default widths and Gray-to-binary helper for the Gray sequence decoder.
package gray_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 4;
  localparam int ERR_CNT_W_DEFAULT  = 8;
  localparam int GRAY_MAX_W         = 32;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    RESYNC   = 2'd2
  } state_e;

  // Bits at or above width are ignored, so callers may zero-extend narrower codes.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int width);
    logic [GRAY_MAX_W-1:0] mask;
    logic [GRAY_MAX_W-1:0] gm;
    logic [GRAY_MAX_W-1:0] b;
    if (width >= GRAY_MAX_W) begin
      mask = {GRAY_MAX_W{1'b1}};
    end else begin
      mask = (GRAY_MAX_W'(1) << width) - GRAY_MAX_W'(1);
    end
    gm = g & mask;
    b = '0;
    b[GRAY_MAX_W-1] = gm[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational WIDTH-bit Gray-to-binary converter.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  // Prefix-XOR conversion from the MSB down.
  always_comb begin
    b = WIDTH'(gray2bin(GRAY_MAX_W'(g), WIDTH));
  end

endmodule

// File: rtl/gray_sequence_decoder.sv
// Decodes a Gray-coded bus, checks for single-step moves and tracks lock/error status.
// Optional GRAY_SYNC_STAGE_EN adds a two-flop input synchronizer (latency 3 instead of 1).
module gray_sequence_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_WIDTH_DEFAULT,
  parameter int ERR_CNT_W = ERR_CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     g_in,
  input  logic                 g_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked
);

  logic [WIDTH-1:0] g_dec_s;
  logic             valid_dec_s;
  logic [WIDTH-1:0] b_s;

`ifdef GRAY_SYNC_STAGE_EN
  logic [WIDTH-1:0] g_s1_q, g_s1_d, g_s2_q, g_s2_d;
  logic             v_s1_q, v_s1_d, v_s2_q, v_s2_d;

  // Synchronizer next-state: shift the input pair through two stages.
  always_comb begin
    g_s1_d = g_in;
    v_s1_d = g_valid;
    g_s2_d = g_s1_q;
    v_s2_d = v_s1_q;
  end

  // Synchronizer flops, cleared by reset so no stale sample survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_s1_q <= '0;
      v_s1_q <= 1'b0;
      g_s2_q <= '0;
      v_s2_q <= 1'b0;
    end else begin
      g_s1_q <= g_s1_d;
      v_s1_q <= v_s1_d;
      g_s2_q <= g_s2_d;
      v_s2_q <= v_s2_d;
    end
  end

  assign g_dec_s     = g_s2_q;
  assign valid_dec_s = v_s2_q;
`else
  assign g_dec_s     = g_in;
  assign valid_dec_s = g_valid;
`endif

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .g (g_dec_s),
    .b (b_s)
  );

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [WIDTH-1:0]     bin_out_q, bin_out_d;
  logic                 bin_valid_q, bin_valid_d;
  logic                 step_up_q, step_up_d;
  logic                 step_down_q, step_down_d;
  logic                 step_err_q, step_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 locked_q, locked_d;

  logic is_hold_s, is_up_s, is_down_s;
  logic [ERR_CNT_W-1:0] err_inc_s;

  // Step classification; for WIDTH=1 +1 equals -1 and is reported as up.
  always_comb begin
    is_hold_s = (b_s == prev_q);
    is_up_s   = (b_s == (prev_q + WIDTH'(1)));
    is_down_s = (b_s == (prev_q - WIDTH'(1))) && !is_up_s;
    if (err_count_q == {ERR_CNT_W{1'b1}}) begin
      err_inc_s = err_count_q;
    end else begin
      err_inc_s = err_count_q + ERR_CNT_W'(1);
    end
  end

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = 1'b0;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    step_err_d  = 1'b0;
    err_count_d = err_count_q;
    locked_d    = locked_q;
    if (valid_dec_s) begin
      prev_d      = b_s;
      bin_out_d   = b_s;
      bin_valid_d = 1'b1;
      case (state_q)
        UNLOCKED: begin
          state_d  = LOCKED;
          locked_d = 1'b1;
        end
        LOCKED, RESYNC: begin
          if (is_hold_s || is_up_s || is_down_s) begin
            step_up_d   = is_up_s;
            step_down_d = is_down_s;
            state_d     = LOCKED;
            locked_d    = 1'b1;
          end else begin
            step_err_d  = 1'b1;
            err_count_d = err_inc_s;
            state_d     = RESYNC;
            locked_d    = 1'b0;
          end
        end
        default: begin
          state_d  = UNLOCKED;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      step_err_q  <= 1'b0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
      step_err_q  <= step_err_d;
      err_count_q <= err_count_d;
      locked_q    <= locked_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign step_up   = step_up_q;
  assign step_down = step_down_q;
  assign step_err  = step_err_q;
  assign err_count = err_count_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_gray_sequence_decoder.sv
// Directed self-checking bench for gray_sequence_decoder (default and GRAY_SYNC_STAGE_EN builds).
module tb_gray_sequence_decoder;

  localparam int W = 4;
`ifdef GRAY_SYNC_STAGE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] g_in = '0;
  logic         g_valid = 1'b0;

  logic [W-1:0] bin_out_a, bin_out_b;
  logic         bin_valid_a, bin_valid_b;
  logic         step_up_a, step_up_b;
  logic         step_down_a, step_down_b;
  logic         step_err_a, step_err_b;
  logic [7:0]   err_count_a;
  logic [1:0]   err_count_b;
  logic         locked_a, locked_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_sequence_decoder #(.WIDTH(W), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .g_in(g_in), .g_valid(g_valid),
    .bin_out(bin_out_a), .bin_valid(bin_valid_a), .step_up(step_up_a),
    .step_down(step_down_a), .step_err(step_err_a), .err_count(err_count_a),
    .locked(locked_a)
  );

  gray_sequence_decoder #(.WIDTH(W), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .g_in(g_in), .g_valid(g_valid),
    .bin_out(bin_out_b), .bin_valid(bin_valid_b), .step_up(step_up_b),
    .step_down(step_down_b), .step_err(step_err_b), .err_count(err_count_b),
    .locked(locked_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_a(input string tag, input int bin, input int bv, input int up,
                          input int dn, input int er, input int cnt, input int lk);
    chk({tag, ".bin_out"},   32'(bin_out_a),   bin);
    chk({tag, ".bin_valid"}, 32'(bin_valid_a), bv);
    chk({tag, ".step_up"},   32'(step_up_a),   up);
    chk({tag, ".step_down"}, 32'(step_down_a), dn);
    chk({tag, ".step_err"},  32'(step_err_a),  er);
    chk({tag, ".err_count"}, 32'(err_count_a), cnt);
    chk({tag, ".locked"},    32'(locked_a),    lk);
  endtask

  task automatic expect_b(input string tag, input int er, input int cnt, input int lk);
    chk({tag, ".b.step_err"},  32'(step_err_b),  er);
    chk({tag, ".b.err_count"}, 32'(err_count_b), cnt);
    chk({tag, ".b.locked"},    32'(locked_b),    lk);
  endtask

  // One valid cycle, then wait until the result is visible on the outputs.
  task automatic send(input logic [W-1:0] g);
    @(negedge clk);
    g_in    = g;
    g_valid = 1'b1;
    @(negedge clk);
    g_valid = 1'b0;
    repeat (LAT-1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    g_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_a("reset", 0, 0, 0, 0, 0, 0, 0);
    expect_b("reset", 0, 0, 0);

    // Counting sequence 0..4
    send(4'b0000); expect_a("first", 0, 1, 0, 0, 0, 0, 1);
    send(4'b0001); expect_a("up1",   1, 1, 1, 0, 0, 0, 1);
    send(4'b0011); expect_a("up2",   2, 1, 1, 0, 0, 0, 1);
    send(4'b0010); expect_a("up3",   3, 1, 1, 0, 0, 0, 1);
    send(4'b0110); expect_a("up4",   4, 1, 1, 0, 0, 0, 1);

    // Gap: pulses drop, levels hold
    @(negedge clk);
    expect_a("gap", 4, 0, 0, 0, 0, 0, 1);

    // Wrap-around up and down
    do_reset();
    send(4'b1000); expect_a("lock15", 15, 1, 0, 0, 0, 0, 1);
    send(4'b0000); expect_a("wrap_up", 0, 1, 1, 0, 0, 0, 1);
    send(4'b1000); expect_a("wrap_dn", 15, 1, 0, 1, 0, 0, 1);

    // Illegal jump 1 -> 3, then legal +1 relocks
    send(4'b0000); expect_a("to0", 0, 1, 1, 0, 0, 0, 1);
    send(4'b0001); expect_a("to1", 1, 1, 1, 0, 0, 0, 1);
    send(4'b0010); expect_a("illegal", 3, 1, 0, 0, 1, 1, 0);
    send(4'b0110); expect_a("relock", 4, 1, 1, 0, 0, 1, 1);

    // Hold on a repeated code
    send(4'b0110); expect_a("hold", 4, 1, 0, 0, 0, 1, 1);

    // Climb to 7, then reset together with a valid sample
    send(4'b0111); expect_a("to5", 5, 1, 1, 0, 0, 1, 1);
    send(4'b0101); expect_a("to6", 6, 1, 1, 0, 0, 1, 1);
    send(4'b0100); expect_a("to7", 7, 1, 1, 0, 0, 1, 1);
    @(negedge clk);
    rst     = 1'b1;
    g_in    = 4'b0110;
    g_valid = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    g_valid = 1'b0;
    expect_a("midrst", 0, 0, 0, 0, 0, 0, 0);
    repeat (LAT) @(negedge clk);
    expect_a("midrst_quiet", 0, 0, 0, 0, 0, 0, 0);
    send(4'b1010); expect_a("lock12", 12, 1, 0, 0, 0, 0, 1);

    // Saturation: 2-bit counter in dut_b sticks at 3, 8-bit in dut_a keeps counting
    do_reset();
    send(4'b0000); expect_b("sat_lock", 0, 0, 1);
    send(4'b1100); expect_b("sat1", 1, 1, 0); expect_a("sat1", 8, 1, 0, 0, 1, 1, 0);
    send(4'b0000); expect_b("sat2", 1, 2, 0);
    send(4'b1100); expect_b("sat3", 1, 3, 0);
    send(4'b0000); expect_b("sat4", 1, 3, 0);
    send(4'b1100); expect_b("sat5", 1, 3, 0); expect_a("sat5", 8, 1, 0, 0, 1, 5, 0);
    // Still in RESYNC: a legal +1 relocks
    send(4'b1101);
    expect_b("sat_relock", 0, 3, 1);
    chk("sat_relock.b.step_up", 32'(step_up_b), 1);
    chk("sat_relock.b.bin_out", 32'(bin_out_b), 9);
    chk("sat_relock.b.bin_valid", 32'(bin_valid_b), 1);
    chk("sat_relock.b.step_down", 32'(step_down_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
